rv32_mem_arbiter: RTL and testbench

//  Parametrised N-port arbiter merging CPU fetch, load/store and future DMA/cache-refill requesters onto a

---
 rtl/rv32_mem_pkg.sv | 26 ++
 rtl/rv32_rr_arbiter.sv | 37 +++
 rtl/rv32_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the RV32 memory arbiter.
//   arb_state_t  : arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   DEF_TIMEOUT  : default ISSUE-cycle budget before an error completion
//   DEF_ERR_DATA : default read data returned on a timed-out transaction
//   cnt_width()  : timeout counter width, never narrower than 1 bit
//   idx_width()  : port index width, never narrower than 1 bit
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam int          DEF_TIMEOUT  = 255;
  localparam logic [31:0] DEF_ERR_DATA = 32'h0;

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational rotating-priority grant.
//   req     : per-port request vector
//   ptr     : index searched first (tie to 0 for fixed priority, port 0 highest)
//   gnt     : one-hot grant
//   gnt_idx : binary index of the granted port
//   any     : at least one request present
module rv32_rr_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 any
);

  always_comb begin
    int p;
    p       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    // Walk the ports starting at ptr, wrapping; first hit wins.
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = (int'(ptr) + k) % NUM_PORTS;
      if (!any && req[p]) begin
        any     = 1'b1;
        gnt[p]  = 1'b1;
        gnt_idx = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// N-port arbiter merging fetch / load-store / DMA requesters onto one
// valid/ready memory port, with one transaction outstanding at a time.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/instr   : per-port request and fetch qualifier
//   req_addr/wdata/wstrb : packed per-port request payload (wstrb 0 = read)
//   req_ready/req_err : one-hot single-cycle completion (+error) pulse
//   req_rdata         : read data, valid with req_ready
//   mem_*             : downstream request, held stable through ISSUE
//   mem_rdata/mem_rdy : downstream completion
//   busy              : FSM not idle
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int               NUM_PORTS = 2,
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               RR_MODE   = 0,
  parameter int               TIMEOUT   = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_instr,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            req_err,
  output logic [DATA_W-1:0]               req_rdata,
  output logic                            mem_valid,
  output logic                            mem_instr,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [(DATA_W/8)-1:0]           mem_wstrb,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_rdy,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam int CNT_W  = cnt_width(TIMEOUT);
  // Expiry fires in the TIMEOUT-th ISSUE cycle, so mem_valid lasts exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_PORTS-1:0][STRB_W-1:0] wstrb_a;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;
  assign wstrb_a = req_wstrb;

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]     rr_ptr_q, arb_ptr, arb_idx, grant_q;
  logic [NUM_PORTS-1:0] arb_gnt, gnt_oh_q;
  logic                 arb_any;

  logic                 sel_instr;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_wstrb;

  logic                 lat_instr_q;
  logic [ADDR_W-1:0]    lat_addr_q;
  logic [DATA_W-1:0]    lat_wdata_q;
  logic [STRB_W-1:0]    lat_wstrb_q;
  logic [DATA_W-1:0]    resp_data_q;
  logic                 err_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 take_req, take_rsp, take_err;
  logic                 in_issue, in_resp;

  // ---------------- arbitration (only consumed in IDLE) ----------------
  assign arb_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

  rv32_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    sel_instr = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt[i]) begin
        sel_instr = req_instr[i];
        sel_addr  = addr_a[i];
        sel_wdata = wdata_a[i];
        sel_wstrb = wstrb_a[i];
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
    take_rsp = 1'b0;
    take_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          take_req = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A completion in the expiry cycle beats the timeout.
        if (mem_rdy) begin
          take_rsp = 1'b1;
          state_d  = ST_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          take_err = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- latched request, counter, response ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q     <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= '0;
      lat_instr_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wstrb_q <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (take_req) begin
        grant_q     <= arb_idx;
        gnt_oh_q    <= arb_gnt;
        lat_instr_q <= sel_instr;
        lat_addr_q  <= sel_addr;
        lat_wdata_q <= sel_wdata;
        lat_wstrb_q <= sel_wstrb;
        cnt_q       <= '0;
        err_q       <= 1'b0;
      end else if (state_q == ST_ISSUE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (take_rsp) resp_data_q <= mem_rdata;
      if (take_err) begin
        resp_data_q <= ERR_DATA;
        err_q       <= 1'b1;
      end
      // Next search starts just past the port that was served.
      if (state_q == ST_RESP && RR_MODE != 0)
        rr_ptr_q <= (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
    end
  end

  // ---------------- outputs: zero outside their owning state ----------------
  assign in_issue  = (state_q == ST_ISSUE);
  assign in_resp   = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

  assign mem_valid = in_issue;
  assign mem_instr = in_issue & lat_instr_q;
  assign mem_addr  = in_issue ? lat_addr_q  : '0;
  assign mem_wdata = in_issue ? lat_wdata_q : '0;
  assign mem_wstrb = in_issue ? lat_wstrb_q : '0;

  assign req_ready = in_resp ? gnt_oh_q : '0;
  assign req_err   = (in_resp && err_q) ? gnt_oh_q : '0;
  assign req_rdata = in_resp ? resp_data_q : '0;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
module tb_rv32_mem_arbiter;
  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hBAD0_E220;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          inst;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          first;
    int          last;
  } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: fixed priority, instance 1: round-robin
  logic [NP-1:0]    rv [2], ri [2], rdy [2], rer [2];
  logic [NP*AW-1:0] ra [2];
  logic [NP*DW-1:0] rw [2];
  logic [NP*SW-1:0] rs [2];
  logic [DW-1:0]    rdat [2], mrd [2], mw [2];
  logic [AW-1:0]    ma [2];
  logic [SW-1:0]    ms [2];
  logic             mv [2], mi [2], mr [2], bsy [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    rv32_mem_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(m), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(rv[m]), .req_instr(ri[m]), .req_addr(ra[m]), .req_wdata(rw[m]), .req_wstrb(rs[m]),
      .req_ready(rdy[m]), .req_err(rer[m]), .req_rdata(rdat[m]),
      .mem_valid(mv[m]), .mem_instr(mi[m]), .mem_addr(ma[m]), .mem_wdata(mw[m]), .mem_wstrb(ms[m]),
      .mem_rdata(mrd[m]), .mem_rdy(mr[m]), .busy(bsy[m])
    );
  end

  int checks = 0;
  int failures = 0;
  int c = 0;

  // reference model state (transaction timeline per instance)
  int          g_cyc [2], r_cyc [2], lat [2], gp [2], ptr [2];
  logic [31:0] rd [2];
  bit          act [2][NP];
  logic        fi [2][NP];
  logic [31:0] fa [2][NP], fw [2][NP];
  logic [3:0]  fs [2][NP];

  rsp_t  rspq [$];
  mreq_t memq [$];

  task automatic chk(input string nm, input int m, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d cyc%0d got=%0h exp=%0h", nm, m, c, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int m = 0; m < 2; m++)
      chk(nm, m, {mv[m], bsy[m], rdy[m], rer[m], rdat[m], mi[m], ma[m], mw[m], ms[m]}, '0);
  endtask

  function automatic int find_rsp(input int m);
    for (int i = 0; i < rspq.size(); i++) if (rspq[i].inst == m) return i;
    return -1;
  endfunction

  function automatic int find_mem(input int m);
    for (int i = 0; i < memq.size(); i++) if (memq[i].inst == m) return i;
    return -1;
  endfunction

  task automatic drive(input int m, input int p, input logic v, input logic i,
                       input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    rv[m][p] = v;
    ri[m][p] = i;
    ra[m][p*AW +: AW] = a;
    rw[m][p*DW +: DW] = w;
    rs[m][p*SW +: SW] = s;
  endtask

  task automatic model_reset();
    rspq.delete();
    memq.delete();
    for (int m = 0; m < 2; m++) begin
      g_cyc[m] = -1; r_cyc[m] = -1; lat[m] = 0; gp[m] = 0; ptr[m] = 0; rd[m] = '0;
      mr[m] = 1'b0; mrd[m] = '0;
      for (int p = 0; p < NP; p++) begin
        act[m][p] = 1'b0;
        drive(m, p, 1'b0, 1'b0, '0, '0, '0);
      end
    end
  endtask

  // Inputs for cycle c, plus the expected outcome of any grant made in cycle c.
  task automatic model_step(input int m);
    int    pick, len;
    rsp_t  er;
    mreq_t eq;
    if (c == r_cyc[m]) act[m][gp[m]] = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (act[m][p] && p == gp[m] && c > g_cyc[m] && c < r_cyc[m])
        // granted and in flight: requester may wander or drop valid
        drive(m, p, 1'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom, 4'($urandom));
      else if (act[m][p])
        drive(m, p, 1'b1, fi[m][p], fa[m][p], fw[m][p], fs[m][p]);
      else if ($urandom_range(0, 7) < 3) begin
        act[m][p] = 1'b1;
        fi[m][p]  = 1'($urandom);
        fa[m][p]  = $urandom;
        fw[m][p]  = $urandom;
        fs[m][p]  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        drive(m, p, 1'b1, fi[m][p], fa[m][p], fw[m][p], fs[m][p]);
      end else
        drive(m, p, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    if (c > r_cyc[m]) begin
      pick = -1;
      for (int k = 0; k < NP; k++) begin
        int q;
        q = (m == 1) ? (ptr[m] + k) % NP : k;
        if (pick < 0 && act[m][q]) pick = q;
      end
      if (pick >= 0) begin
        lat[m]   = $urandom_range(1, 6);
        len      = (lat[m] < TO) ? lat[m] : TO;
        g_cyc[m] = c;
        r_cyc[m] = c + len + 1;
        rd[m]    = $urandom;
        gp[m]    = pick;
        ptr[m]   = (pick + 1) % NP;
        eq.inst = m; eq.instr = fi[m][pick]; eq.addr = fa[m][pick];
        eq.wdata = fw[m][pick]; eq.wstrb = fs[m][pick]; eq.first = c + 1; eq.last = c + len;
        memq.push_back(eq);
        er.inst = m; er.port = pick; er.err = (lat[m] > TO);
        er.data = er.err ? ERRD : rd[m]; er.cyc = r_cyc[m];
        rspq.push_back(er);
      end
    end
    if (c > g_cyc[m] && c < r_cyc[m]) begin
      mr[m]  = ((c - g_cyc[m]) == lat[m]);
      mrd[m] = mr[m] ? rd[m] : $urandom;
    end else begin
      mr[m]  = ($urandom_range(0, 3) == 0);   // stray completions must be ignored
      mrd[m] = $urandom;
    end
  endtask

  task automatic monitor(input int m);
    int    mx, rx;
    logic  exp_busy, in_win;
    rsp_t  e;
    exp_busy = (c > g_cyc[m]) && (c <= r_cyc[m]);
    chk("busy", m, bsy[m], exp_busy);
    mx = find_mem(m);
    if (mx >= 0 && memq[mx].last < c) begin
      memq.delete(mx);
      mx = find_mem(m);
    end
    in_win = (mx >= 0) && (memq[mx].first <= c) && (c <= memq[mx].last);
    chk("mem_valid", m, mv[m], in_win);
    if (mv[m] && in_win)
      chk("mem_req", m, {mi[m], ma[m], mw[m], ms[m]},
          {memq[mx].instr, memq[mx].addr, memq[mx].wdata, memq[mx].wstrb});
    if (!exp_busy)
      chk("idle_outputs", m, {mi[m], ma[m], mw[m], ms[m], rdat[m]}, '0);
    rx = find_rsp(m);
    if (rdy[m] != '0) begin
      if (rx < 0) chk("unexpected_ready", m, rdy[m], '0);
      else begin
        e = rspq[rx];
        chk("ready_port", m, rdy[m], 1 << e.port);
        chk("err", m, rer[m], e.err ? (1 << e.port) : 0);
        chk("rdata", m, rdat[m], e.data);
        chk("ready_cycle", m, c, e.cyc);
        rspq.delete(rx);
      end
    end else begin
      chk("err_no_ready", m, rer[m], '0);
      if (rx >= 0 && rspq[rx].cyc < c) begin
        chk("missing_ready", m, c, rspq[rx].cyc);
        rspq.delete(rx);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    c++;
    #2;
    monitor(0);
    monitor(1);
    @(negedge clk);
    model_step(0);
    model_step(1);
  endtask

  initial begin
    bit found;
    model_reset();
    for (int m = 0; m < 2; m++) rv[m] = '1;   // requests during reset are ignored
    repeat (3) @(posedge clk);
    #2 chk_zero("reset_state");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    model_step(0);
    model_step(1);
    for (int k = 0; k < 1500; k++) step();

    // reset in the middle of an ISSUE on the fixed-priority instance
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (g_cyc[0] < c + 1 && c + 1 < r_cyc[0]) found = 1'b1;
    end
    chk("issue_window_found", 0, found, 1'b1);
    @(posedge clk);
    c++;
    #2;
    monitor(0);
    monitor(1);
    #1 rst = 1'b1;
    #1 chk_zero("async_reset");
    for (int m = 0; m < 2; m++) begin
      rv[m] = '1;
      mr[m] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #2 chk_zero("reset_hold");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    model_step(0);
    model_step(1);
    for (int k = 0; k < 1500; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
